// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: operation encodings,
// frame states and the decode of which operations advance a frame.
package shift_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        SHL   = 3'd1,
        SHR   = 3'd2,
        ASR   = 3'd3,
        ROL   = 3'd4,
        ROR   = 3'd5,
        LOAD  = 3'd6,
        CLEAR = 3'd7
    } shift_mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } frame_state_e;

    // Only operations that move a bit out of the register advance a frame.
    function automatic logic is_counted(input shift_mode_e mode);
        logic counted;
        case (mode)
            SHL, SHR, ASR, ROL, ROR: counted = 1'b1;
            default:                 counted = 1'b0;
        endcase
        return counted;
    endfunction

endpackage

// File: rtl/shift_frame_ctr.sv
// Frame tracker: counts bit-moving operations after a LOAD and pulses
// done when WIDTH of them have completed a serialise/deserialise pass.
module shift_frame_ctr
    import shift_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          en_i,
    input  logic          counted_i,
    input  logic          load_i,
    input  logic          clear_i,
    output logic [CW-1:0] cnt_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    frame_state_e  state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          done, done_nxt;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    // done is a single-cycle pulse, so it defaults low even when en_i is 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        if (en_i) begin
            if (load_i) begin
                cnt_nxt   = '0;
                state_nxt = ACTIVE;
            end else if (clear_i) begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end else if (counted_i && (state == ACTIVE)) begin
                if (cnt == LAST) begin
                    cnt_nxt   = FULL;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
        end
    end

    assign cnt_o  = cnt;
    assign busy_o = (state == ACTIVE);
    assign done_o = done;

endmodule

// File: rtl/shift_register_univ.sv
// Parametrised universal shift register with shift/rotate/arithmetic,
// parallel load, clear, and a frame counter flagging a full WIDTH-bit pass.
module shift_register_univ
    import shift_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic             ser_i,
    input  logic [WIDTH-1:0] par_i,
    output logic [WIDTH-1:0] out_o,
    output logic             shout_o,
    output logic [CW-1:0]    cnt_o,
    output logic             busy_o,
    output logic             done_o
);

    shift_mode_e      mode;
    logic [WIDTH-1:0] data_q;
    logic             shout_q;

    assign mode = shift_mode_e'(mode_i);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            data_q  <= '0;
            shout_q <= 1'b0;
        end else if (en_i) begin
            case (mode)
                HOLD: ;
                SHL: begin
                    data_q  <= {data_q[WIDTH-2:0], ser_i};
                    shout_q <= data_q[WIDTH-1];
                end
                SHR: begin
                    data_q  <= {ser_i, data_q[WIDTH-1:1]};
                    shout_q <= data_q[0];
                end
                ASR: begin
                    data_q  <= {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    shout_q <= data_q[0];
                end
                ROL: begin
                    data_q  <= {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    shout_q <= data_q[WIDTH-1];
                end
                ROR: begin
                    data_q  <= {data_q[0], data_q[WIDTH-1:1]};
                    shout_q <= data_q[0];
                end
                LOAD: begin
                    data_q  <= par_i;
                    shout_q <= 1'b0;
                end
                CLEAR: begin
                    data_q  <= '0;
                    shout_q <= 1'b0;
                end
            endcase
        end
    end

    shift_frame_ctr #(
        .WIDTH(WIDTH)
    ) u_frame_ctr (
        .clk      (clk),
        .resetb   (resetb),
        .en_i     (en_i),
        .counted_i(is_counted(mode)),
        .load_i   (mode == LOAD),
        .clear_i  (mode == CLEAR),
        .cnt_o    (cnt_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    assign out_o   = data_q;
    assign shout_o = shout_q;

endmodule

// File: tb/tb_shift_register_univ.sv
// Self-checking bench: vector table, directed frame scenarios, random
// stimulus against an arithmetic reference model, and a WIDTH sweep.
module tb_shift_register_univ;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        resetb;
    logic        en;
    logic [2:0]  mode;
    logic        ser;
    logic [15:0] par;
    logic [15:0] out;
    logic        shout;
    logic [4:0]  cnt;
    logic        busy;
    logic        done;

    logic        sw_en;
    logic [2:0]  sw_mode;
    logic        sw_ser;
    logic [1:0]  par2,  out2;
    logic [7:0]  par8,  out8;
    logic [63:0] par64, out64;
    logic [1:0]  cnt2;
    logic [3:0]  cnt8;
    logic [6:0]  cnt64;
    logic        sh2, sh8, sh64, busy2, busy8, busy64, done2, done8, done64;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_out;
    logic        m_sh;
    int          m_cnt;
    logic        m_busy;
    logic        m_done;

    typedef struct {
        logic        en;
        logic [2:0]  mode;
        logic        ser;
        logic [15:0] par;
        logic [15:0] exp_out;
        logic        exp_sh;
        int          exp_cnt;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t tbl[16];

    always #5 clk = ~clk;

    shift_register_univ #(.WIDTH(16)) dut (
        .clk(clk), .resetb(resetb), .en_i(en), .mode_i(mode), .ser_i(ser), .par_i(par),
        .out_o(out), .shout_o(shout), .cnt_o(cnt), .busy_o(busy), .done_o(done)
    );
    shift_register_univ #(.WIDTH(2)) dut2 (
        .clk(clk), .resetb(resetb), .en_i(sw_en), .mode_i(sw_mode), .ser_i(sw_ser), .par_i(par2),
        .out_o(out2), .shout_o(sh2), .cnt_o(cnt2), .busy_o(busy2), .done_o(done2)
    );
    shift_register_univ #(.WIDTH(8)) dut8 (
        .clk(clk), .resetb(resetb), .en_i(sw_en), .mode_i(sw_mode), .ser_i(sw_ser), .par_i(par8),
        .out_o(out8), .shout_o(sh8), .cnt_o(cnt8), .busy_o(busy8), .done_o(done8)
    );
    shift_register_univ #(.WIDTH(64)) dut64 (
        .clk(clk), .resetb(resetb), .en_i(sw_en), .mode_i(sw_mode), .ser_i(sw_ser), .par_i(par64),
        .out_o(out64), .shout_o(sh64), .cnt_o(cnt64), .busy_o(busy64), .done_o(done64)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_out  = '0;
        m_sh   = 1'b0;
        m_cnt  = 0;
        m_busy = 1'b0;
        m_done = 1'b0;
    endtask

    // Reference behaviour expressed as word arithmetic and a frame tally.
    task automatic model_step(input logic e, input logic [2:0] md, input logic s, input logic [15:0] p);
        int unsigned v;
        int unsigned si;
        v      = m_out;
        si     = s;
        m_done = 1'b0;
        if (!e) return;
        case (md)
            SHL: begin m_sh = v / 32768;  m_out = 16'((v * 2 + si) % 65536); end
            SHR: begin m_sh = v % 2;      m_out = 16'(v / 2 + si * 32768); end
            ASR: begin m_sh = v % 2;      m_out = 16'(v / 2 + ((v >= 32768) ? 32768 : 0)); end
            ROL: begin m_sh = v / 32768;  m_out = 16'((v * 2) % 65536 + v / 32768); end
            ROR: begin m_sh = v % 2;      m_out = 16'(v / 2 + (v % 2) * 32768); end
            LOAD: begin m_sh = 1'b0; m_out = p; m_cnt = 0; m_busy = 1'b1; end
            CLEAR: begin m_sh = 1'b0; m_out = '0; m_cnt = 0; m_busy = 1'b0; end
            default: ;
        endcase
        if (md >= 3'd1 && md <= 3'd5 && m_busy) begin
            m_cnt++;
            if (m_cnt == 16) begin
                m_done = 1'b1;
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic apply_stimulus(input logic e, input logic [2:0] md, input logic s, input logic [15:0] p);
        en   = e;
        mode = md;
        ser  = s;
        par  = p;
        model_step(e, md, s, p);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name);
        check_output({name, ".out"},   64'(out),   64'(m_out));
        check_output({name, ".shout"}, 64'(shout), 64'(m_sh));
        check_output({name, ".cnt"},   64'(cnt),   64'(m_cnt));
        check_output({name, ".busy"},  64'(busy),  64'(m_busy));
        check_output({name, ".done"},  64'(done),  64'(m_done));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] pattern;
        logic [15:0] word;
        int          done_at;
        int          d2, d8, d64;

        tbl[0]  = '{1'b1, LOAD,  1'b0, 16'h8001, 16'h8001, 1'b0, 0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, ROL,   1'b0, 16'h0000, 16'h0003, 1'b1, 1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, ROL,   1'b0, 16'h0000, 16'h0006, 1'b0, 2, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, ROL,   1'b0, 16'h0000, 16'h000C, 1'b0, 3, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, ROL,   1'b0, 16'h0000, 16'h0018, 1'b0, 4, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, LOAD,  1'b0, 16'h8000, 16'h8000, 1'b0, 0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, ASR,   1'b0, 16'h0000, 16'hC000, 1'b0, 1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, ASR,   1'b0, 16'h0000, 16'hE000, 1'b0, 2, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, ASR,   1'b0, 16'h0000, 16'hF000, 1'b0, 3, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, CLEAR, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, LOAD,  1'b0, 16'hFFFF, 16'h0000, 1'b0, 0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, SHL,   1'b1, 16'h0000, 16'h0001, 1'b0, 0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, SHR,   1'b0, 16'h0000, 16'h0000, 1'b1, 0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, LOAD,  1'b0, 16'h1234, 16'h1234, 1'b0, 0, 1'b1, 1'b0};
        tbl[14] = '{1'b1, ROR,   1'b0, 16'h0000, 16'h091A, 1'b0, 1, 1'b1, 1'b0};
        tbl[15] = '{1'b1, HOLD,  1'b1, 16'hFFFF, 16'h091A, 1'b0, 1, 1'b1, 1'b0};

        resetb  = 1'b0;
        en = 1'b0; mode = HOLD; ser = 1'b0; par = '0;
        sw_en = 1'b0; sw_mode = HOLD; sw_ser = 1'b0; par2 = '0; par8 = '0; par64 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        resetb = 1'b1;

        for (int i = 0; i < 16; i++) begin
            apply_stimulus(tbl[i].en, tbl[i].mode, tbl[i].ser, tbl[i].par);
            check_output($sformatf("vec%0d.out", i),   64'(out),   64'(tbl[i].exp_out));
            check_output($sformatf("vec%0d.shout", i), 64'(shout), 64'(tbl[i].exp_sh));
            check_output($sformatf("vec%0d.cnt", i),   64'(cnt),   64'(tbl[i].exp_cnt));
            check_output($sformatf("vec%0d.busy", i),  64'(busy),  64'(tbl[i].exp_busy));
            check_output($sformatf("vec%0d.done", i),  64'(done),  64'(tbl[i].exp_done));
        end

        pattern = 16'hA5C3;
        apply_stimulus(1'b1, LOAD, 1'b0, pattern);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, SHL, 1'b0, 16'h0000);
            check_output($sformatf("ser.shout%0d", i), 64'(shout), 64'(pattern[15 - i]));
            check_output($sformatf("ser.done%0d", i),  64'(done),  64'(i == 15));
        end
        check_output("ser.out",  64'(out),  64'h0);
        check_output("ser.cnt",  64'(cnt),  64'd16);
        check_output("ser.busy", 64'(busy), 64'd0);
        apply_stimulus(1'b1, HOLD, 1'b0, 16'h0000);
        check_output("ser.done_after", 64'(done), 64'd0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, SHL, 1'b1, 16'h0000);
            check_output($sformatf("idle.cnt%0d", i),  64'(cnt),  64'd16);
            check_output($sformatf("idle.done%0d", i), 64'(done), 64'd0);
        end

        word = 16'h1234;
        apply_stimulus(1'b1, LOAD, 1'b0, 16'h0000);
        for (int i = 0; i < 16; i++) apply_stimulus(1'b1, SHR, word[i], 16'h0000);
        check_output("deser.out",  64'(out),  64'h1234);
        check_output("deser.done", 64'(done), 64'd1);

        apply_stimulus(1'b1, LOAD, 1'b0, 16'hBEEF);
        for (int i = 0; i < 15; i++) apply_stimulus(1'b1, ROR, 1'b0, 16'h0000);
        check_output("reload.cnt15", 64'(cnt), 64'd15);
        apply_stimulus(1'b1, LOAD, 1'b0, 16'h0F0F);
        check_output("reload.done", 64'(done), 64'd0);
        check_output("reload.cnt",  64'(cnt),  64'd0);
        check_output("reload.busy", 64'(busy), 64'd1);

        apply_stimulus(1'b1, LOAD, 1'b0, 16'hC3C3);
        done_at = -1;
        for (int c = 1; c <= 40; c++) begin
            apply_stimulus(!(c >= 9 && c <= 13), SHL, c[0], 16'h0000);
            if (done && done_at < 0) done_at = c;
        end
        check_output("stall.done_cycle", 64'(done_at), 64'd21);
        check_model("stall.end");

        for (int i = 0; i < 400; i++) begin
            int          r;
            logic [2:0]  md;
            r  = $urandom_range(0, 19);
            md = (r == 0) ? CLEAR : (r <= 2) ? LOAD : 3'($urandom_range(0, 5));
            apply_stimulus($urandom_range(0, 9) != 0, md, 1'($urandom), 16'($urandom));
            check_model($sformatf("rand%0d", i));
        end

        apply_stimulus(1'b1, LOAD, 1'b0, 16'hFFFF);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, SHR, 1'b1, 16'h0000);
        #2;
        resetb = 1'b0;
        model_reset();
        #1;
        check_model("async_reset");
        @(negedge clk);
        resetb = 1'b1;
        apply_stimulus(1'b0, LOAD, 1'b1, 16'hABCD);
        check_model("hold_en0");

        sw_en = 1'b1; sw_mode = LOAD; sw_ser = 1'b0;
        par2 = '1; par8 = '1; par64 = '1;
        @(posedge clk);
        #1;
        d2 = -1; d8 = -1; d64 = -1;
        for (int i = 1; i <= 70; i++) begin
            sw_mode = SHL;
            @(posedge clk);
            #1;
            if (done2 && d2 < 0) begin
                d2 = i;
                check_output("sweep2.out", 64'(out2), 64'h0);
                check_output("sweep2.cnt", 64'(cnt2), 64'd2);
            end
            if (done8 && d8 < 0) begin
                d8 = i;
                check_output("sweep8.out", 64'(out8), 64'h0);
                check_output("sweep8.cnt", 64'(cnt8), 64'd8);
            end
            if (done64 && d64 < 0) begin
                d64 = i;
                check_output("sweep64.out", out64, 64'h0);
                check_output("sweep64.cnt", 64'(cnt64), 64'd64);
            end
        end
        check_output("sweep2.done_cycle",  64'(d2),  64'd2);
        check_output("sweep8.done_cycle",  64'(d8),  64'd8);
        check_output("sweep64.done_cycle", 64'(d64), 64'd64);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
